mem_arbiter: RTL

Shares one single-ported unified memory between the instruction-fetch port and the data-memory port of the 5-stage MIPS32 pipeline. It accepts level requests from both stages, serialises them onto a req/ack memory bus, and returns read data with a one-cycle ack pulse. It also drives the stall signals that freeze IF or MEM while their access is outstanding. A watchdog flags memory that never answers on the sticky `err`.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_watchdog.sv | 31 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and parameter defaults for the unified-memory arbiter.
// Used by both the arbiter FSM and its watchdog timer.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int DATA_STREAK_MAX_DEF = 4;
    localparam int TIMEOUT_DEF         = 255;

endpackage

// File: rtl/mem_watchdog.sv
// Memory-response watchdog: an 8-bit down-counter loaded on each grant.
// It expires on the ISSUE cycle where the count reaches zero without an ack.
module mem_watchdog
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic ack,
    output logic expire
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= 8'(TIMEOUT);
        end else if (run && !ack && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // An ack in the terminal cycle wins over the abort.
    assign expire = run && !ack && (r_cnt == 8'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and MEM pipeline ports onto one single-ported memory bus.
// Data wins ties until it has taken DATA_STREAK_MAX grants over a waiting fetch.
//
// state | meaning
// IDLE  | arbitrate; on a grant latch owner and transaction fields
// ISSUE | m_req high, fields frozen; wait for m_ack or watchdog expiry
// RESP  | one-cycle ack pulse to the owner; no arbitration
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_STREAK_MAX = DATA_STREAK_MAX_DEF,
    parameter int TIMEOUT         = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    arb_state_t  r_state;
    owner_t      r_owner;
    mem_req_t    r_mreq;
    logic        r_m_req;
    logic        r_i_ack;
    logic        r_d_ack;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic [2:0]  r_streak;
    logic        r_err;

    logic        w_streak_full;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_grant;
    logic        w_expire;
    logic        w_done;
    logic [31:0] w_resp_data;
    mem_req_t    w_fields;

    always_comb begin
        w_streak_full = (r_streak == 3'(DATA_STREAK_MAX));
        w_grant_d     = (r_state == IDLE) && d_req && !(i_req && w_streak_full);
        w_grant_i     = (r_state == IDLE) && i_req && !w_grant_d;
        w_grant       = w_grant_i || w_grant_d;
        w_fields      = '{we: 1'b0, be: 4'hF, addr: i_addr, wdata: 32'd0};
        if (w_grant_d) begin
            w_fields = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
        end
        w_done        = (r_state == ISSUE) && (m_ack || w_expire);
        // An aborted transaction returns zero read data.
        w_resp_data   = m_ack ? m_rdata : 32'd0;
    end

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (w_grant),
        .run    (r_state == ISSUE),
        .ack    (m_ack),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_mreq    <= '0;
            r_m_req   <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_streak  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grant_d ? OWN_D : OWN_I;
                        r_mreq  <= w_fields;
                        r_m_req <= 1'b1;
                        r_state <= ISSUE;
                        if (w_grant_d && i_req) begin
                            if (r_streak != 3'd7) begin
                                r_streak <= r_streak + 3'd1;
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (w_done) begin
                        r_m_req <= 1'b0;
                        r_state <= RESP;
                        if (!m_ack) begin
                            r_err <= 1'b1;
                        end
                        if (r_owner == OWN_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= w_resp_data;
                        end else begin
                            r_d_ack <= 1'b1;
                            if (!r_mreq.we) begin
                                r_d_rdata <= w_resp_data;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = r_i_rdata;
    assign i_ack     = r_i_ack;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = r_d_ack;
    assign m_req     = r_m_req;
    assign m_we      = r_mreq.we;
    assign m_be      = r_mreq.be;
    assign m_addr    = r_mreq.addr;
    assign m_wdata   = r_mreq.wdata;
    assign stall_if  = i_req & ~r_i_ack;
    assign stall_mem = d_req & ~r_d_ack;
    assign err       = r_err;

endmodule
